// File: rtl/i2c_reg_sequencer.sv
// Register read/write sequencer that drives a byte-level I2C controller; optional controller
// stall timeout is compiled in with `define I2C_SEQ_TIMEOUT_EN (otherwise waits are unbounded).
module i2c_reg_sequencer #(
  parameter logic [1:0]  CLK_DVSR       = 2'b00,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       rw,
  input  logic [6:0] dev_addr,
  input  logic [7:0] reg_addr,
  input  logic [7:0] wdata,
  output logic       busy,
  output logic       done,
  output logic [7:0] rdata,
  output logic       nack_err,
  output logic       timeout_err,
  output logic       i2c_wr,
  output logic [2:0] i2c_cmd,
  output logic [7:0] i2c_din,
  output logic [1:0] i2c_clk_dvsr,
  input  logic       i2c_rdy,
  input  logic       i2c_ack,
  input  logic [7:0] i2c_dout
);

  localparam logic [2:0] CMD_STOP    = 3'b001;
  localparam logic [2:0] CMD_READ    = 3'b010;
  localparam logic [2:0] CMD_WRITE   = 3'b011;
  localparam logic [2:0] CMD_RESTART = 3'b100;
  localparam logic [2:0] CMD_START   = 3'b101;

  typedef enum logic [2:0] {
    S_IDLE, S_ISSUE, S_WAIT_LO, S_WAIT_HI, S_CHECK, S_FINISH
  } state_t;

  state_t     r_state;
  logic [2:0] r_step;
  logic       r_rw;
  logic [6:0] r_dev;
  logic [7:0] r_reg;
  logic [7:0] r_wdata;
  logic       r_busy;
  logic       r_done;
  logic       r_nack;
  logic       r_wr;
  logic [2:0] r_cmd;
  logic [7:0] r_din;
  logic [7:0] r_rdata;

  logic [10:0] w_next;
  logic [2:0]  w_stop_step;
  logic        w_tmo;

  // Command/data for a given step; any step past the last data phase is STOP.
  function automatic logic [10:0] f_cmd(input logic [2:0] step, input logic rd,
                                        input logic [6:0] dev, input logic [7:0] ra,
                                        input logic [7:0] wd);
    logic [10:0] v;
    v = {CMD_STOP, 8'h00};
    case (step)
      3'd0:    v = {CMD_START, 8'h00};
      3'd1:    v = {CMD_WRITE, dev, 1'b0};
      3'd2:    v = {CMD_WRITE, ra};
      3'd3:    v = rd ? {CMD_RESTART, 8'h00} : {CMD_WRITE, wd};
      3'd4:    if (rd) v = {CMD_WRITE, dev, 1'b1};
      3'd5:    if (rd) v = {CMD_READ, 8'hFF};
      default: ;
    endcase
    return v;
  endfunction

  assign w_next      = f_cmd(r_step + 3'd1, r_rw, r_dev, r_reg, r_wdata);
  assign w_stop_step = r_rw ? 3'd6 : 3'd4;

`ifdef I2C_SEQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TMO_W-1:0] r_tmo_cnt;
  logic             r_tmo;
  logic             w_in_wait;
  logic             w_prog;

  assign w_in_wait = (r_state == S_ISSUE) || (r_state == S_WAIT_LO) || (r_state == S_WAIT_HI);
  assign w_prog    = ((r_state == S_ISSUE)   &&  i2c_rdy) ||
                     ((r_state == S_WAIT_LO) && !i2c_rdy) ||
                     ((r_state == S_WAIT_HI) &&  i2c_rdy);
  // Count of cycles already spent in the current wait state; zero on entry.
  assign w_tmo = w_in_wait && !w_prog && (r_tmo_cnt == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= '0;
    end else if (w_in_wait && !w_prog && !w_tmo) begin
      r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
    end else begin
      r_tmo_cnt <= '0;
    end
  end

  assign timeout_err = r_tmo;
`else
  logic w_unused_tmo_cfg;
  assign w_unused_tmo_cfg = (TIMEOUT_CYCLES != 0);
  assign w_tmo            = 1'b0;
  assign timeout_err      = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_step  <= 3'd0;
      r_rw    <= 1'b0;
      r_dev   <= 7'd0;
      r_reg   <= 8'd0;
      r_wdata <= 8'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_nack  <= 1'b0;
      r_wr    <= 1'b0;
      r_cmd   <= 3'd0;
      r_din   <= 8'd0;
      r_rdata <= 8'd0;
`ifdef I2C_SEQ_TIMEOUT_EN
      r_tmo   <= 1'b0;
`endif
    end else begin
      r_done <= 1'b0;
      r_wr   <= 1'b0;
      if (w_tmo) begin
        // Stalled controller: abandon without STOP.
        r_state <= S_FINISH;
        r_done  <= 1'b1;
        r_busy  <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
        r_tmo   <= 1'b1;
`endif
      end else begin
        case (r_state)
          S_IDLE: begin
            if (start) begin
              r_rw             <= rw;
              r_dev            <= dev_addr;
              r_reg            <= reg_addr;
              r_wdata          <= wdata;
              r_busy           <= 1'b1;
              r_nack           <= 1'b0;
`ifdef I2C_SEQ_TIMEOUT_EN
              r_tmo            <= 1'b0;
`endif
              r_step           <= 3'd0;
              {r_cmd, r_din}   <= {CMD_START, 8'h00};
              r_state          <= S_ISSUE;
            end
          end
          S_ISSUE: begin
            if (i2c_rdy) begin
              r_wr    <= 1'b1;
              r_state <= S_WAIT_LO;
            end
          end
          S_WAIT_LO: if (!i2c_rdy) r_state <= S_WAIT_HI;
          S_WAIT_HI: if (i2c_rdy)  r_state <= S_CHECK;
          S_CHECK: begin
            if (r_cmd == CMD_STOP) begin
              r_state <= S_FINISH;
              r_done  <= 1'b1;
              r_busy  <= 1'b0;
            end else if ((r_cmd == CMD_WRITE) && i2c_ack) begin
              r_nack         <= 1'b1;
              r_step         <= w_stop_step;
              {r_cmd, r_din} <= {CMD_STOP, 8'h00};
              r_state        <= S_ISSUE;
            end else begin
              if (r_cmd == CMD_READ) r_rdata <= i2c_dout;
              r_step         <= r_step + 3'd1;
              {r_cmd, r_din} <= w_next;
              r_state        <= S_ISSUE;
            end
          end
          S_FINISH: r_state <= S_IDLE;
          default:  r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign rdata        = r_rdata;
  assign nack_err     = r_nack;
  assign i2c_wr       = r_wr;
  assign i2c_cmd      = r_cmd;
  assign i2c_din      = r_din;
  assign i2c_clk_dvsr = CLK_DVSR;

endmodule

// File: tb/tb_i2c_reg_sequencer.sv
// Bench for i2c_reg_sequencer: behavioural I2C controller/slave model plus command and
// completion scoreboards fed by directed transactions.
`timescale 1ns/1ps
module tb_i2c_reg_sequencer;

  localparam logic [1:0] DVSR = 2'b01;
  localparam int         TMO  = 100;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       rw = 1'b0;
  logic [6:0] dev_addr = 7'd0;
  logic [7:0] reg_addr = 8'd0;
  logic [7:0] wdata = 8'd0;
  logic       busy, done, nack_err, timeout_err, i2c_wr;
  logic [7:0] rdata, i2c_din;
  logic [2:0] i2c_cmd;
  logic [1:0] i2c_clk_dvsr;
  logic       i2c_rdy = 1'b1;
  logic       i2c_ack = 1'b0;
  logic [7:0] i2c_dout = 8'h00;

  always #5 clk = ~clk;

  i2c_reg_sequencer #(.CLK_DVSR(DVSR), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .start(start), .rw(rw), .dev_addr(dev_addr),
    .reg_addr(reg_addr), .wdata(wdata), .busy(busy), .done(done), .rdata(rdata),
    .nack_err(nack_err), .timeout_err(timeout_err), .i2c_wr(i2c_wr), .i2c_cmd(i2c_cmd),
    .i2c_din(i2c_din), .i2c_clk_dvsr(i2c_clk_dvsr), .i2c_rdy(i2c_rdy), .i2c_ack(i2c_ack),
    .i2c_dout(i2c_dout)
  );

  int          n_checks = 0;
  int          n_errors = 0;
  int          n_done   = 0;
  logic [10:0] exp_cmd_q[$];
  logic [9:0]  exp_done_q[$];

  int         nack_at    = -1;
  logic [7:0] slave_data = 8'h00;
  logic       hold_low   = 1'b0;
  int         ctl_cnt    = 0;
  int         cmd_idx    = 0;
  logic       prev_wr    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Controller + slave: accepts a command on i2c_wr, stays not-ready for 3 cycles.
  always @(negedge clk) begin
    if (hold_low) begin
      i2c_rdy = 1'b0;
      ctl_cnt = 0;
    end else if (ctl_cnt > 0) begin
      ctl_cnt--;
      if (ctl_cnt == 0) i2c_rdy = 1'b1;
    end else if (i2c_wr) begin
      if (i2c_cmd == 3'b101) cmd_idx = 0;
      i2c_ack = (cmd_idx == nack_at);
      if (i2c_cmd == 3'b010) i2c_dout = slave_data;
      i2c_rdy = 1'b0;
      ctl_cnt = 3;
      cmd_idx++;
    end else begin
      i2c_rdy = 1'b1;
    end
  end

  // Monitor: every command strobe and every done pulse is checked against the queues.
  always @(negedge clk) begin
    logic [10:0] ec;
    logic [9:0]  ed;
    if (!rst) begin
      if (i2c_wr) begin
        check("wr_single_cycle", {31'd0, prev_wr}, 32'd0);
        if (exp_cmd_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_cmd: got cmd=%b din=%h expected no command", i2c_cmd, i2c_din);
        end else begin
          ec = exp_cmd_q.pop_front();
          check("cmd_din", {21'd0, i2c_cmd, i2c_din}, {21'd0, ec});
        end
      end
      if (done) begin
        n_done++;
        check("busy_low_at_done", {31'd0, busy}, 32'd0);
        if (exp_done_q.size() == 0) begin
          n_checks++;
          n_errors++;
          $display("FAIL unexpected_done: got done nack=%b tmo=%b expected no done", nack_err, timeout_err);
        end else begin
          ed = exp_done_q.pop_front();
          check("done_nack_tmo_rdata", {22'd0, nack_err, timeout_err, rdata}, {22'd0, ed});
        end
      end
    end
    prev_wr = i2c_wr;
  end

  task automatic push_cmd(input logic [2:0] c, input logic [7:0] d);
    exp_cmd_q.push_back({c, d});
  endtask

  task automatic push_done(input logic nk, input logic to, input logic [7:0] rd);
    exp_done_q.push_back({nk, to, rd});
  endtask

  task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] ra, input logic [7:0] wd);
    @(negedge clk);
    start = 1'b1; rw = r; dev_addr = d; reg_addr = ra; wdata = wd;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_done(input string name, input int budget, output int lat);
    lat = 1;
    while (!done && lat < budget) begin
      @(negedge clk);
      lat++;
    end
    if (!done) begin
      n_checks++;
      n_errors++;
      $display("FAIL %s: got no done within %0d cycles, expected a done pulse", name, budget);
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    int base;
    int nwr;
    int k;

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_wr", {31'd0, i2c_wr}, 32'd0);
    check("rst_cmd", {29'd0, i2c_cmd}, 32'd0);
    check("rst_din", {24'd0, i2c_din}, 32'd0);
    check("rst_rdata", {24'd0, rdata}, 32'd0);
    check("rst_nack", {31'd0, nack_err}, 32'd0);
    check("rst_tmo", {31'd0, timeout_err}, 32'd0);
    check("clk_dvsr", {30'd0, i2c_clk_dvsr}, 32'h1);

`ifdef I2C_SEQ_TIMEOUT_EN
    hold_low = 1'b1;
    push_done(1'b0, 1'b1, 8'h00);
    issue(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done("timeout_done", 1000, lat);
    check("timeout_latency", lat - 3, TMO + 1);
    hold_low = 1'b0;
    repeat (5) @(negedge clk);
`endif

    // Plain write, all ACK.
    push_cmd(3'b101, 8'h00); push_cmd(3'b011, 8'hA0); push_cmd(3'b011, 8'h10);
    push_cmd(3'b011, 8'hA5); push_cmd(3'b001, 8'h00);
    push_done(1'b0, 1'b0, 8'h00);
    issue(1'b0, 7'h50, 8'h10, 8'hA5);
    wait_done("write_done", 2000, lat);

    // Register read returning 3C.
    slave_data = 8'h3C;
    push_cmd(3'b101, 8'h00); push_cmd(3'b011, 8'hA0); push_cmd(3'b011, 8'h20);
    push_cmd(3'b100, 8'h00); push_cmd(3'b011, 8'hA1); push_cmd(3'b010, 8'hFF);
    push_cmd(3'b001, 8'h00);
    push_done(1'b0, 1'b0, 8'h3C);
    issue(1'b1, 7'h50, 8'h20, 8'h00);
    wait_done("read_done", 2000, lat);

    // NACK on the device address: straight to STOP.
    nack_at = 1;
    push_cmd(3'b101, 8'h00); push_cmd(3'b011, 8'h44); push_cmd(3'b001, 8'h00);
    push_done(1'b1, 1'b0, 8'h3C);
    issue(1'b0, 7'h22, 8'h33, 8'h44);
    wait_done("nack_addr_done", 2000, lat);

    // ack=1 during STOP must not raise nack_err.
    nack_at = 4;
    push_cmd(3'b101, 8'h00); push_cmd(3'b011, 8'hA0); push_cmd(3'b011, 8'h11);
    push_cmd(3'b011, 8'h99); push_cmd(3'b001, 8'h00);
    push_done(1'b0, 1'b0, 8'h3C);
    issue(1'b0, 7'h50, 8'h11, 8'h99);
    wait_done("stop_ack_done", 2000, lat);

    // NACK on the read-direction address after RESTART.
    push_cmd(3'b101, 8'h00); push_cmd(3'b011, 8'hA0); push_cmd(3'b011, 8'h07);
    push_cmd(3'b100, 8'h00); push_cmd(3'b011, 8'hA1); push_cmd(3'b001, 8'h00);
    push_done(1'b1, 1'b0, 8'h3C);
    issue(1'b1, 7'h50, 8'h07, 8'h00);
    wait_done("nack_read_addr_done", 2000, lat);
    nack_at = -1;

    // Second start while busy is ignored.
    base = n_done;
    push_cmd(3'b101, 8'h00); push_cmd(3'b011, 8'h22); push_cmd(3'b011, 8'h5A);
    push_cmd(3'b011, 8'hC3); push_cmd(3'b001, 8'h00);
    push_done(1'b0, 1'b0, 8'h3C);
    issue(1'b0, 7'h11, 8'h5A, 8'hC3);
    repeat (8) @(negedge clk);
    start = 1'b1; rw = 1'b1; dev_addr = 7'h7F; reg_addr = 8'hEE; wdata = 8'h01;
    @(negedge clk);
    start = 1'b0;
    wait_done("busy_start_done", 2000, lat);
    repeat (20) @(negedge clk);
    check("single_done_pulse", n_done - base, 1);

    // Reset while waiting for rdy to return on the reg_addr byte.
    push_cmd(3'b101, 8'h00); push_cmd(3'b011, 8'hA0); push_cmd(3'b011, 8'h20);
    issue(1'b1, 7'h50, 8'h20, 8'h00);
    nwr = 0;
    k = 0;
    while (nwr < 3 && k < 2000) begin
      @(negedge clk);
      k++;
      if (i2c_wr) nwr++;
    end
    check("reach_reg_byte", nwr, 3);
    @(negedge clk);
    rst = 1'b1;
    base = n_done;
    @(negedge clk);
    check("mid_rst_busy", {31'd0, busy}, 32'd0);
    check("mid_rst_done", {31'd0, done}, 32'd0);
    check("mid_rst_wr", {31'd0, i2c_wr}, 32'd0);
    check("mid_rst_cmd", {29'd0, i2c_cmd}, 32'd0);
    check("mid_rst_din", {24'd0, i2c_din}, 32'd0);
    check("mid_rst_rdata", {24'd0, rdata}, 32'd0);
    check("mid_rst_nack", {31'd0, nack_err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (20) @(negedge clk);
    check("mid_rst_no_done", n_done - base, 0);

    // Recovery after reset.
    push_cmd(3'b101, 8'h00); push_cmd(3'b011, 8'h54); push_cmd(3'b011, 8'h01);
    push_cmd(3'b011, 8'h00); push_cmd(3'b001, 8'h00);
    push_done(1'b0, 1'b0, 8'h00);
    issue(1'b0, 7'h2A, 8'h01, 8'h00);
    wait_done("recover_done", 2000, lat);

    repeat (10) @(negedge clk);
    check("cmd_queue_empty", exp_cmd_q.size(), 0);
    check("done_queue_empty", exp_done_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
